// File: rtl/interrupt_controller.sv
// IF/IE interrupt flag block: edge-detects requests, presents IF&IE, dispatches RST vectors on ack.
// Latency: reads 1 cycle, vector valid 1 cycle after ack; backpressure: none, CPU holds ack until done.
module interrupt_controller #(
    parameter int          NUM_IRQ = 5,
    parameter logic [15:0] IF_ADDR = 16'hFF0F,
    parameter logic [15:0] IE_ADDR = 16'hFFFF
) (
    input  logic               i_Clk,
    input  logic               i_Reset,
    input  logic               i_Enable,
    input  logic [NUM_IRQ-1:0] i_Requests,
    input  logic [15:0]        i_Address,
    input  logic               i_Write,
    input  logic               i_Read,
    input  logic [7:0]         i_Data,
    output logic [7:0]         o_Data,
    output logic               o_Data_Valid,
    output logic [NUM_IRQ-1:0] o_Interrupts,
    input  logic               i_Handle_Interrupt,
    output logic [7:0]         o_Vector,
    output logic               o_Vector_Valid
);
    localparam int IDX_W = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;

    typedef enum logic {IDLE, ACK} state_t;

    state_t             state, state_next;
    logic [NUM_IRQ-1:0] if_q, req_q, req_edge, ack_clr, if_next;
    logic [7:0]         ie_q, vec_next, if_rd;
    logic [IDX_W-1:0]   idx;
    logic               any_pending;
    logic               wr_if, wr_ie;

    assign wr_if          = i_Write && (i_Address == IF_ADDR);
    assign wr_ie          = i_Write && (i_Address == IE_ADDR);
    assign req_edge       = i_Requests & ~req_q;
    assign o_Interrupts   = if_q & ie_q[NUM_IRQ-1:0];
    assign o_Vector_Valid = (state == ACK);

    // Unimplemented flag bits read back as ones.
    always_comb begin
        if_rd = 8'hFF;
        if_rd[NUM_IRQ-1:0] = if_q;
    end

    // Scan high to low so the lowest (highest-priority) pending bit wins.
    always_comb begin
        idx = '0;
        any_pending = 1'b0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (o_Interrupts[i]) begin
                idx = IDX_W'(i);
                any_pending = 1'b1;
            end
        end
    end

    always_comb begin
        state_next = state;
        ack_clr    = '0;
        vec_next   = o_Vector;
        case (state)
            IDLE: begin
                if (i_Handle_Interrupt) begin
                    state_next = ACK;
                    if (any_pending) begin
                        ack_clr  = NUM_IRQ'(1) << idx;
                        vec_next = 8'h40 + 8'({idx, 3'b000});
                    end else begin
                        vec_next = 8'h00;
                    end
                end
            end
            ACK: begin
                if (!i_Handle_Interrupt) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // A fresh request edge overrides both the ack clear and a bus write.
    assign if_next = ((wr_if ? i_Data[NUM_IRQ-1:0] : if_q) & ~ack_clr) | req_edge;

    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            state        <= IDLE;
            if_q         <= '0;
            ie_q         <= 8'h00;
            req_q        <= '0;
            o_Vector     <= 8'h00;
            o_Data       <= 8'h00;
            o_Data_Valid <= 1'b0;
        end else if (i_Enable) begin
            state    <= state_next;
            if_q     <= if_next;
            req_q    <= i_Requests;
            o_Vector <= vec_next;
            if (wr_ie) ie_q <= i_Data;
            if (i_Read && i_Address == IF_ADDR) begin
                o_Data       <= if_rd;
                o_Data_Valid <= 1'b1;
            end else if (i_Read && i_Address == IE_ADDR) begin
                o_Data       <= ie_q;
                o_Data_Valid <= 1'b1;
            end else begin
                o_Data       <= 8'h00;
                o_Data_Valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_interrupt_controller.sv
// Bench for interrupt_controller: directed scenarios, read data scoreboarded through a queue.
module tb_interrupt_controller;
    logic       i_Clk = 1'b0;
    logic       i_Reset, i_Enable, i_Write, i_Read, i_Handle_Interrupt;
    logic [4:0] i_Requests;
    logic [15:0] i_Address;
    logic [7:0] i_Data;
    logic [7:0] o_Data, o_Vector;
    logic       o_Data_Valid, o_Vector_Valid;
    logic [4:0] o_Interrupts;

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q[$];

    interrupt_controller dut (
        .i_Clk(i_Clk), .i_Reset(i_Reset), .i_Enable(i_Enable),
        .i_Requests(i_Requests), .i_Address(i_Address), .i_Write(i_Write),
        .i_Read(i_Read), .i_Data(i_Data), .o_Data(o_Data),
        .o_Data_Valid(o_Data_Valid), .o_Interrupts(o_Interrupts),
        .i_Handle_Interrupt(i_Handle_Interrupt), .o_Vector(o_Vector),
        .o_Vector_Valid(o_Vector_Valid)
    );

    always #5 i_Clk = ~i_Clk;

    task automatic tick();
        @(posedge i_Clk);
        #1;
    endtask

    task automatic wr(input logic [15:0] a, input logic [7:0] d);
        i_Address = a; i_Data = d; i_Write = 1'b1;
        tick();
        i_Write = 1'b0;
    endtask

    // Issues one read and waits a bounded number of cycles for the response.
    task automatic rd(input logic [15:0] a, output logic [7:0] d, output logic got);
        i_Address = a; i_Read = 1'b1;
        tick();
        i_Read = 1'b0;
        got = 1'b0;
        d = 8'h00;
        for (int k = 0; k < 4 && !got; k++) begin
            if (o_Data_Valid) begin
                got = 1'b1;
                d = o_Data;
            end else begin
                tick();
            end
        end
    endtask

    task automatic sb_read(input string name, input logic [15:0] a, input logic [7:0] e);
        logic [7:0] d, x;
        logic got;
        exp_q.push_back(e);
        rd(a, d, got);
        x = exp_q.pop_front();
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL %s: no read response, expected %02h", name, x);
        end else if (d !== x) begin
            errors++;
            $display("FAIL %s: got %02h expected %02h", name, d, x);
        end
    endtask

    task automatic test_reset();
        i_Reset = 1'b1; i_Enable = 1'b1; i_Write = 1'b0; i_Read = 1'b0;
        i_Handle_Interrupt = 1'b0; i_Requests = '0; i_Address = '0; i_Data = '0;
        tick(); tick();
        checks++;
        if ({o_Data, o_Data_Valid, o_Vector, o_Vector_Valid, o_Interrupts} !== 23'h0) begin
            errors++;
            $display("FAIL reset_outputs: data=%02h dv=%b vec=%02h vv=%b irq=%b expected all 0",
                     o_Data, o_Data_Valid, o_Vector, o_Vector_Valid, o_Interrupts);
        end
        i_Reset = 1'b0;
        tick();
        sb_read("reset_if", 16'hFF0F, 8'hE0);
        sb_read("reset_ie", 16'hFFFF, 8'h00);
    endtask

    task automatic test_request();
        wr(16'hFFFF, 8'h1F);
        i_Requests = 5'b00100;
        tick();
        i_Requests = '0;
        tick();
        checks++;
        if (o_Interrupts !== 5'b00100) begin
            errors++;
            $display("FAIL req_irq: got %b expected 00100", o_Interrupts);
        end
        sb_read("req_if", 16'hFF0F, 8'hE4);
        sb_read("req_ie", 16'hFFFF, 8'h1F);
        i_Address = 16'h1234; i_Read = 1'b1;
        tick();
        i_Read = 1'b0;
        checks++;
        if (o_Data_Valid !== 1'b0 || o_Data !== 8'h00) begin
            errors++;
            $display("FAIL other_addr: dv=%b data=%02h expected 0/00", o_Data_Valid, o_Data);
        end
        wr(16'h1234, 8'h00);
        sb_read("other_write_ignored", 16'hFFFF, 8'h1F);
    endtask

    task automatic test_ack();
        wr(16'hFF0F, 8'h16);
        i_Handle_Interrupt = 1'b1;
        tick();
        checks++;
        if (o_Vector_Valid !== 1'b1 || o_Vector !== 8'h48) begin
            errors++;
            $display("FAIL ack_vector: vv=%b vec=%02h expected 1/48", o_Vector_Valid, o_Vector);
        end
        checks++;
        if (o_Interrupts !== 5'b10100) begin
            errors++;
            $display("FAIL ack_clear: got %b expected 10100", o_Interrupts);
        end
        tick(); tick(); tick();
        checks++;
        if (o_Vector_Valid !== 1'b1 || o_Vector !== 8'h48 || o_Interrupts !== 5'b10100) begin
            errors++;
            $display("FAIL ack_hold: vv=%b vec=%02h irq=%b expected 1/48/10100",
                     o_Vector_Valid, o_Vector, o_Interrupts);
        end
        i_Handle_Interrupt = 1'b0;
        tick();
        checks++;
        if (o_Vector_Valid !== 1'b0) begin
            errors++;
            $display("FAIL ack_release: vv=%b expected 0", o_Vector_Valid);
        end
        sb_read("ack_if", 16'hFF0F, 8'hF4);
    endtask

    task automatic test_cancel();
        wr(16'hFFFF, 8'h00);
        wr(16'hFF0F, 8'h1F);
        i_Handle_Interrupt = 1'b1;
        tick();
        checks++;
        if (o_Vector_Valid !== 1'b1 || o_Vector !== 8'h00) begin
            errors++;
            $display("FAIL cancel_vector: vv=%b vec=%02h expected 1/00", o_Vector_Valid, o_Vector);
        end
        i_Handle_Interrupt = 1'b0;
        tick();
        sb_read("cancel_if", 16'hFF0F, 8'hFF);
    endtask

    task automatic test_same_cycle();
        i_Address = 16'hFF0F; i_Data = 8'h00; i_Write = 1'b1;
        i_Requests = 5'b00001;
        tick();
        i_Write = 1'b0;
        sb_read("edge_beats_write", 16'hFF0F, 8'hE1);
        wr(16'hFF0F, 8'h00);
        for (int k = 0; k < 6; k++) tick();
        sb_read("held_level_once", 16'hFF0F, 8'hE0);
        i_Requests = '0;
        tick();
    endtask

    task automatic test_reset_in_ack();
        wr(16'hFFFF, 8'h1F);
        wr(16'hFF0F, 8'h01);
        i_Handle_Interrupt = 1'b1;
        tick();
        i_Reset = 1'b1;
        tick();
        checks++;
        if ({o_Data, o_Data_Valid, o_Vector, o_Vector_Valid, o_Interrupts} !== 23'h0) begin
            errors++;
            $display("FAIL reset_in_ack: data=%02h dv=%b vec=%02h vv=%b irq=%b expected all 0",
                     o_Data, o_Data_Valid, o_Vector, o_Vector_Valid, o_Interrupts);
        end
        i_Reset = 1'b0; i_Handle_Interrupt = 1'b0;
        tick();
        sb_read("reset_in_ack_ie", 16'hFFFF, 8'h00);
        sb_read("reset_in_ack_if", 16'hFF0F, 8'hE0);
    endtask

    task automatic test_enable();
        wr(16'hFFFF, 8'h1F);
        i_Enable = 1'b0;
        wr(16'hFFFF, 8'h00);
        wr(16'hFF0F, 8'h1F);
        i_Requests = 5'b01000; i_Handle_Interrupt = 1'b1;
        tick(); tick();
        checks++;
        if (o_Interrupts !== 5'b00000 || o_Vector_Valid !== 1'b0) begin
            errors++;
            $display("FAIL enable_frozen: irq=%b vv=%b expected 00000/0", o_Interrupts, o_Vector_Valid);
        end
        i_Handle_Interrupt = 1'b0; i_Enable = 1'b1;
        tick();
        checks++;
        if (o_Interrupts !== 5'b01000) begin
            errors++;
            $display("FAIL enable_edge: got %b expected 01000", o_Interrupts);
        end
        sb_read("enable_ie", 16'hFFFF, 8'h1F);
        sb_read("enable_if", 16'hFF0F, 8'hE8);
        i_Requests = '0;
        tick();
    endtask

    initial begin
        test_reset();
        test_request();
        test_ack();
        test_cancel();
        test_same_cycle();
        test_reset_in_ack();
        test_enable();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
